// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the pipeline data-memory access controller.
package mem_ctrl_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam int TIMER_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating wait-cycle counter; expired_o flags the enabled cycle that brings it to the limit.
module cycle_timer #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W:0]   count_inc;

    assign count_inc = {1'b0, count_q} + {{W{1'b0}}, 1'b1};

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != {W{1'b1}})) begin
            count_d = count_inc[W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Looks one step ahead so the limit-th waiting cycle is the last one.
    assign expired_o = enable_i && (count_inc >= {1'b0, limit_i});

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one held memory request per access and stalls the pipeline.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] WData_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] RData_o,
    output logic              RData_valid_o,
    output logic              err_o
);

    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              is_write_q, is_write_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    logic              stall_c;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expired;
    logic              req_present;
    logic              req_ok;

    assign req_present = MemRead_i | MemWrite_i;
    assign req_ok      = (MemRead_i ^ MemWrite_i) && word_aligned(Addr_i[1:0]);

    cycle_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .limit_i  (TIMER_LIMIT),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        is_write_d  = is_write_q;
        stall_c     = 1'b0;
        timer_clear = 1'b1;
        timer_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_present) begin
                    stall_c = 1'b1;
                    if (req_ok) begin
                        state_d    = ST_REQ;
                        addr_d     = Addr_i;
                        wdata_d    = WData_i;
                        is_write_d = MemWrite_i;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_REQ: begin
                stall_c     = 1'b1;
                timer_clear = 1'b0;
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                    if (!is_write_q) begin
                        rdata_d = mem_rdata_i;
                    end
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) begin
                        state_d = ST_ERR;
                    end
                end
            end
            // The pipeline advances at the end of DONE, so its inputs still show the old access.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                stall_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_d    = (state_d == ST_REQ);
        we_d     = (state_d == ST_REQ) && is_write_d;
        rvalid_d = (state_q == ST_REQ) && (state_d == ST_DONE) && !is_write_q;
        err_d    = (state_d == ST_ERR);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            is_write_q <= is_write_d;
            req_q      <= req_d;
            we_q       <= we_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    assign stall_o       = rst_i & stall_c;
    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign RData_o       = rdata_q;
    assign RData_valid_o = rvalid_q;
    assign err_o         = err_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data bus and address width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum REQ-state cycles allowed without mem_ack_i (range 1..1023).
REQ-003 clk_i  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 MemRead_i  input  1  SHALL be the load request from the EX/MEM pipeline register.
REQ-006 MemWrite_i  input  1  SHALL be the store request from the EX/MEM pipeline register.
REQ-007 Addr_i  input  DATA_W  SHALL be the byte address (ALU result).
REQ-008 WData_i  input  DATA_W  SHALL be the store data.
REQ-009 mem_req_o  output  1  SHALL be the memory request, held until acknowledged.
REQ-010 mem_we_o  output  1  SHALL be the write enable (1 store, 0 load), valid while mem_req_o=1.
REQ-011 mem_addr_o, mem_wdata_o  output  DATA_W each  SHALL be the registered address and store data.
REQ-012 mem_ack_i  input  1  SHALL be the memory acknowledge, one cycle per transfer.
REQ-013 mem_rdata_i  input  DATA_W  SHALL be the load data, valid with mem_ack_i.
REQ-014 stall_o  output  1  SHALL freeze the PC and all pipeline registers when 1.
REQ-015 RData_o  output  DATA_W  SHALL hold the captured load data.
REQ-016 RData_valid_o  output  1  SHALL pulse for one cycle when RData_o is new.
REQ-017 err_o  output  1  SHALL flag a sticky access error.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DONE and ERR.
REQ-019 In IDLE, exactly one of MemRead_i/MemWrite_i high with Addr_i[1:0]=0 SHALL latch Addr_i, WData_i and the read/write type, then move to REQ.
REQ-020 In IDLE, MemRead_i and MemWrite_i both high, or a request with Addr_i[1:0]!=0, SHALL move to ERR without issuing mem_req_o.
REQ-021 stall_o SHALL be combinationally 1 in IDLE while a request is present, 1 throughout REQ and ERR, and 0 in DONE and in idle IDLE.
REQ-022 In REQ, mem_req_o SHALL be 1, with mem_addr_o, mem_wdata_o and mem_we_o stable until the ack cycle.
REQ-023 A sampled mem_ack_i in REQ SHALL move to DONE, and for loads SHALL capture mem_rdata_i into RData_o.
REQ-024 DONE SHALL last one cycle and return to IDLE; it SHALL ignore MemRead_i/MemWrite_i, because the pipeline advances at that edge.
REQ-025 RData_valid_o SHALL be 1 only in DONE after a load; RData_o SHALL hold its value until the next load completes.
REQ-026 mem_ack_i outside REQ SHALL be ignored.
REQ-027 The REQ cycle counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-028 When the counter reaches TIMEOUT with no ack, the FSM SHALL enter ERR, and mem_req_o SHALL be 0 from the next cycle.
REQ-029 ERR SHALL be absorbing until reset, with err_o=1 and stall_o=1.
REQ-030 Minimum access latency SHALL be 3 cycles (IDLE detect, REQ with ack, DONE); each additional ack wait adds 1 cycle.

Reset
REQ-031 With rst_i=0 at a rising edge, the state SHALL become IDLE, the counter 0, and all registered outputs (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, RData_o, RData_valid_o, err_o) 0.
REQ-032 stall_o SHALL be 0 while rst_i=0, independent of inputs.
REQ-033 Reset during REQ SHALL abort the access; mem_req_o SHALL be 0 in the cycle after the reset edge, and a late ack SHALL be ignored.

Structure
REQ-034 Package mem_ctrl_pkg SHALL hold the state enum, the DATA_W default and the TIMEOUT default.
REQ-035 The timeout counter SHALL be a sub-module named cycle_timer, with clear, enable, limit and expired ports.

Verification
REQ-036 Load, addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> stall_o high for 2 cycles, RData_o=0xDEADBEEF with RData_valid_o pulse in cycle 3.
REQ-037 Store, addr 0x204, data 0x12345678, ack after 4 REQ cycles -> mem_req_o/mem_we_o=1 for 5 cycles, mem_wdata_o stable, no RData_valid_o.
REQ-038 Load, addr 0x103 -> ERR next cycle, err_o=1, mem_req_o never asserted, stall_o stays 1.
REQ-039 TIMEOUT=8, no ack -> mem_req_o high for 8 cycles, then ERR with err_o=1.
REQ-040 Reset pulled low in the 2nd REQ cycle, ack arrives next cycle -> IDLE, all outputs 0, ack ignored.
REQ-041 Back-to-back load then store -> second access starts in IDLE after DONE, with no double issue of the first access.
